// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder: the requester drives start/a/b,
// the adder returns status and the registered sum.
interface serial_adder_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic             val;

  modport master (
    output start, a, b,
    input  busy, done, y, cout, val
  );

  modport slave (
    input  start, a, b,
    output busy, done, y, cout, val
  );
endinterface

// File: rtl/serial_adder_unit.sv
// Bit-serial unsigned adder: one full adder and a carry flop walk the operands LSB
// first; the WIDTH+1-bit result and its threshold flag are published only when done.
module serial_adder_unit #(
  parameter int          WIDTH  = 4,
  parameter int unsigned THRESH = 5
) (
  input logic         clk,
  input logic         rst,
  serial_adder_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH:0]     THRESH_V = (WIDTH + 1)'(THRESH);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             cout_q, cout_d;
  logic             val_q, val_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] next_sum;

  // The flag looks at the full sum including carry, so a wrapped y can still be >= THRESH.
  function automatic logic below_thresh(input logic [WIDTH:0] full_sum);
    return full_sum < THRESH_V;
  endfunction

  assign fa_s     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign fa_c     = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
  assign next_sum = {fa_s, sum_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    cout_d   = cout_q;
    val_d    = val_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = RUN;
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          sum_sh_d = '0;
          carry_d  = 1'b0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        sum_sh_d = next_sum;
        carry_d  = fa_c;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          y_d     = next_sum;
          cout_d  = fa_c;
          val_d   = below_thresh({fa_c, next_sum});
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      y_q      <= '0;
      cout_q   <= 1'b0;
      val_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      cout_q   <= cout_d;
      val_q    <= val_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.y    = y_q;
  assign bus.cout = cout_q;
  assign bus.val  = val_q;

endmodule

// File: doc/serial_adder_unit.md
SERIAL_ADDER_UNIT -- requirements
Module: serial_adder_unit

Interface
REQ-001 Parameter WIDTH, default 4: operand and sum width in bits, legal range 2..16.
REQ-002 Parameter THRESH, default 5: compare threshold for val, unsigned, WIDTH+1 bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 a  input  WIDTH  operand A, unsigned; captured on accepted start.
REQ-007 b  input  WIDTH  operand B, unsigned; captured on accepted start.
REQ-008 busy  output  1  high in RUN and DONE states.
REQ-009 done  output  1  one-cycle pulse, high only in DONE state.
REQ-010 y  output  WIDTH  registered sum a+b, low WIDTH bits.
REQ-011 cout  output  1  registered carry-out of the sum.
REQ-012 val  output  1  registered flag, 1 when {cout,y} < THRESH.

Function
REQ-013 The block SHALL compute a+b bit-serially, LSB first, with one full-adder stage and a 1-bit carry register, carry-in 0.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 IDLE SHALL move to RUN on a rising edge with start=1, latching a and b into shift registers, clearing the carry and the bit counter.
REQ-016 IDLE SHALL remain in IDLE when start=0; y, cout, val hold their last values.
REQ-017 RUN SHALL process one bit per edge: sum bit into the result shift register, carry register updated, operands shifted right, counter incremented.
REQ-018 RUN SHALL move to DONE on the edge that processes bit WIDTH-1, loading y, cout and val on that same edge.
REQ-019 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-020 Latency: start accepted on edge k gives done=1 in the cycle after edge k+WIDTH, with y/cout/val valid from that cycle onward.
REQ-021 start asserted in RUN or DONE SHALL be ignored, with no queuing; a new request is accepted only after the return to IDLE.
REQ-022 Throughput: back-to-back requests SHALL be accepted at most once per WIDTH+2 cycles.
REQ-023 Changes on a/b after acceptance SHALL have no effect on the current result.
REQ-024 Overflow SHALL wrap: y = (a+b) mod 2^WIDTH, cout = bit WIDTH of a+b.
REQ-025 val SHALL be evaluated on the full WIDTH+1-bit sum, never on y alone.
REQ-026 y, cout and val SHALL change only on the RUN-to-DONE edge, never mid-computation.

Reset
REQ-027 rst=1 SHALL immediately force IDLE and set y=0, cout=0, val=0, busy=0, done=0, and clear the carry, counter and shift registers, regardless of clock.
REQ-028 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-029 The first rising edge after rst deasserts SHALL be able to accept start.

Verification
REQ-030 Reset then a=3, b=1, start for 1 cycle -> done after WIDTH+1 cycles; y=4, cout=0, val=1.
REQ-031 a=9, b=9 -> y=2, cout=1, val=0 (sum 18 >= 5, even though y<5).
REQ-032 a=15, b=0, then start held high continuously -> busy high for 5 cycles, done pulses once per 6 cycles; y=15, val=0 each time.
REQ-033 Accept a=2, b=2, then drive a=7, b=7 with start=1 during RUN -> result y=4, val=1; the second request is ignored.
REQ-034 Assert rst at the second RUN cycle of a=8, b=8 -> all outputs 0 at once, no done pulse; a subsequent a=1, b=3 gives y=4, val=1.
REQ-035 Exhaustive sweep of all 256 (a,b) pairs at WIDTH=4 against a+b and <5 -> no mismatches.
